bin_frame_scanner: RTL and testbench

- Downstream consumer of the ram_control binary frame buffer.
- When ram_control signals a new frame, the block walks read_index across all pixels and reads the 1-bit bin_out.
- It accumulates the set-pixel count, bounding box and coordinate sums, then computes an integer centroid with a sequential divider.
- Results feed the tracking/game logic. An external mux gives this block ownership of read_index while busy; VGA owns it otherwise.

---
 rtl/bin_frame_scanner.sv | 209 ++++++++++++++++++++
 tb/tb_bin_frame_scanner.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_frame_scanner.sv
// Scans a binary frame buffer after each frame-ready edge and reports the set-pixel
// count, bounding box and integer centroid, computed with a sequential divider.
module bin_frame_scanner #(
  parameter int WIDTH   = 4,
  parameter int HEIGHT  = 4,
  parameter int LOGSIZE = 4,
  parameter int LOGW    = 2,
  parameter int LOGH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  output logic [LOGSIZE-1:0] read_index,
  input  logic               bin_in,
  output logic               busy,
  output logic               done,
  output logic               empty,
  output logic [LOGSIZE:0]   count,
  output logic [LOGW-1:0]    min_x,
  output logic [LOGW-1:0]    max_x,
  output logic [LOGH-1:0]    min_y,
  output logic [LOGH-1:0]    max_y,
  output logic [LOGW-1:0]    cent_x,
  output logic [LOGH-1:0]    cent_y
);

  localparam int N    = WIDTH * HEIGHT;
  localparam int DIVN = (LOGW > LOGH) ? LOGW : LOGH;
  localparam int SXW  = LOGW + LOGSIZE + 1;
  localparam int SYW  = LOGH + LOGSIZE + 1;
  localparam int DW   = ((SXW > SYW) ? SXW : SYW) + DIVN;
  localparam int DCW  = $clog2(DIVN + 1) + 1;
  localparam logic [LOGSIZE-1:0] LAST_IDX = LOGSIZE'(N - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic               ready_q;
  logic               start;
  logic [LOGSIZE-1:0] idx;
  logic [LOGSIZE-1:0] pix_idx;
  logic               pix_valid;
  logic [LOGW-1:0]    pix_x;
  logic [LOGH-1:0]    pix_y;

  logic [LOGSIZE:0]   acc_count;
  logic [SXW-1:0]     sum_x;
  logic [SYW-1:0]     sum_y;
  logic [LOGW-1:0]    acc_min_x, acc_max_x;
  logic [LOGH-1:0]    acc_min_y, acc_max_y;

  logic [DW-1:0]      rem_x, rem_y, dsr;
  logic [DIVN-1:0]    q_x, q_y, q_x_nxt, q_y_nxt;
  logic [DCW-1:0]     div_cnt;
  logic               x_ge, y_ge;
  logic               last_div;

  always_comb begin
    start      = ready && !ready_q;
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    read_index = '0;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        busy       = 1'b1;
        read_index = idx;
        if (idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        read_index = idx;
        state_nxt  = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (last_div) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_x    = LOGW'(32'(pix_idx) % WIDTH);
    pix_y    = LOGH'(32'(pix_idx) / WIDTH);
    x_ge     = rem_x >= dsr;
    y_ge     = rem_y >= dsr;
    q_x_nxt  = DIVN'({q_x, x_ge});
    q_y_nxt  = DIVN'({q_y, y_ge});
    last_div = div_cnt == DCW'(DIVN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      idx       <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ready_q   <= ready;
      pix_valid <= (state == SCAN);
      pix_idx   <= idx;
      case (state)
        SCAN:    if (idx != LAST_IDX) idx <= idx + 1'b1;
        DRAIN:   idx <= idx;
        default: idx <= '0;
      endcase
    end
  end

  // bin_in belongs to the index driven one cycle earlier, tracked by pix_idx/pix_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_count <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      acc_min_x <= '0;
      acc_max_x <= '0;
      acc_min_y <= '0;
      acc_max_y <= '0;
    end else if (state == IDLE && start) begin
      acc_count <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      acc_min_x <= '1;
      acc_max_x <= '0;
      acc_min_y <= '1;
      acc_max_y <= '0;
    end else if (pix_valid && bin_in) begin
      acc_count <= acc_count + 1'b1;
      sum_x     <= sum_x + SXW'(pix_x);
      sum_y     <= sum_y + SYW'(pix_y);
      if (pix_x < acc_min_x) acc_min_x <= pix_x;
      if (pix_x > acc_max_x) acc_max_x <= pix_x;
      if (pix_y < acc_min_y) acc_min_y <= pix_y;
      if (pix_y > acc_max_y) acc_max_y <= pix_y;
    end
  end

  // First DIV cycle loads the divider; DIVN compare-subtract steps follow, MSB first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_x   <= '0;
      rem_y   <= '0;
      dsr     <= '0;
      q_x     <= '0;
      q_y     <= '0;
      div_cnt <= '0;
    end else if (state == DIV) begin
      div_cnt <= div_cnt + 1'b1;
      if (div_cnt == '0) begin
        rem_x <= DW'(sum_x);
        rem_y <= DW'(sum_y);
        dsr   <= DW'(acc_count) << (DIVN - 1);
        q_x   <= '0;
        q_y   <= '0;
      end else if (acc_count != '0) begin
        if (x_ge) rem_x <= rem_x - dsr;
        if (y_ge) rem_y <= rem_y - dsr;
        q_x <= q_x_nxt;
        q_y <= q_y_nxt;
        dsr <= dsr >> 1;
      end
    end else begin
      div_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      empty  <= 1'b1;
      count  <= '0;
      min_x  <= '0;
      max_x  <= '0;
      min_y  <= '0;
      max_y  <= '0;
      cent_x <= '0;
      cent_y <= '0;
    end else if (state == DIV && last_div) begin
      count <= acc_count;
      if (acc_count == '0) begin
        empty  <= 1'b1;
        min_x  <= '0;
        max_x  <= '0;
        min_y  <= '0;
        max_y  <= '0;
        cent_x <= '0;
        cent_y <= '0;
      end else begin
        empty  <= 1'b0;
        min_x  <= acc_min_x;
        max_x  <= acc_max_x;
        min_y  <= acc_min_y;
        max_y  <= acc_max_y;
        cent_x <= LOGW'(q_x_nxt);
        cent_y <= LOGH'(q_y_nxt);
      end
    end
  end

endmodule

// File: tb/tb_bin_frame_scanner.sv
// Randomized and directed frames for bin_frame_scanner, checked against a
// pixel-list reference model of count, bounding box and centroid.
module tb_bin_frame_scanner;

  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 4;
  localparam int LOGSIZE = 4;
  localparam int LOGW    = 2;
  localparam int LOGH    = 2;
  localparam int N       = WIDTH * HEIGHT;
  localparam int LAT     = 20;

  logic               clk = 1'b0;
  logic               reset;
  logic               ready;
  logic               bin_in = 1'b0;
  logic [LOGSIZE-1:0] read_index;
  logic               busy, done, empty;
  logic [LOGSIZE:0]   count;
  logic [LOGW-1:0]    min_x, max_x, cent_x;
  logic [LOGH-1:0]    min_y, max_y, cent_y;

  int errors = 0;
  int checks = 0;
  bit frame [N];
  int last_idx = 0;

  typedef struct {
    int cnt;
    int mnx, mxx, mny, mxy;
    int cx, cy;
    int emp;
  } exp_t;

  bin_frame_scanner #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LOGSIZE(LOGSIZE), .LOGW(LOGW), .LOGH(LOGH)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .read_index(read_index), .bin_in(bin_in),
    .busy(busy), .done(done), .empty(empty), .count(count),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
    .cent_x(cent_x), .cent_y(cent_y)
  );

  always #5 clk = ~clk;

  // Frame RAM with one cycle of read latency
  always @(negedge clk) begin
    bin_in   = frame[last_idx];
    last_idx = int'(read_index);
  end

  function automatic exp_t ref_model();
    exp_t e;
    int sx, sy;
    sx = 0; sy = 0;
    e.cnt = 0; e.mnx = WIDTH; e.mxx = -1; e.mny = HEIGHT; e.mxy = -1;
    for (int k = 0; k < N; k++) begin
      if (frame[k]) begin
        e.cnt++;
        sx += k % WIDTH;
        sy += k / WIDTH;
        if (k % WIDTH < e.mnx) e.mnx = k % WIDTH;
        if (k % WIDTH > e.mxx) e.mxx = k % WIDTH;
        if (k / WIDTH < e.mny) e.mny = k / WIDTH;
        if (k / WIDTH > e.mxy) e.mxy = k / WIDTH;
      end
    end
    if (e.cnt == 0) begin
      e.mnx = 0; e.mxx = 0; e.mny = 0; e.mxy = 0; e.cx = 0; e.cy = 0; e.emp = 1;
    end else begin
      e.cx = sx / e.cnt; e.cy = sy / e.cnt; e.emp = 0;
    end
    return e;
  endfunction

  function automatic logic [17:0] pack_exp(input exp_t e);
    return {e.emp[0], 5'(e.cnt), 2'(e.mnx), 2'(e.mxx), 2'(e.mny), 2'(e.mxy), 2'(e.cx), 2'(e.cy)};
  endfunction

  function automatic logic [17:0] pack_got();
    return {empty, count, min_x, max_x, min_y, max_y, cent_x, cent_y};
  endfunction

  task automatic load_mask(input logic [15:0] mask);
    for (int k = 0; k < N; k++) frame[k] = mask[k];
  endtask

  // Produces a ready rising edge at E0, then observes cycles E0+k until done
  task automatic run_scan(input int pulse_at, input int reset_at,
                          output int done_at, output int busy_bad);
    done_at  = -1;
    busy_bad = 0;
    @(negedge clk); ready = 1'b0;
    @(negedge clk); ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == reset_at) begin
        reset = 1'b0;
        ready = 1'b0;
        #1;
        break;
      end
      if (k == pulse_at) ready = 1'b0;
      if (k == pulse_at + 1) ready = 1'b1;
      if (done === 1'b1) begin
        done_at = k;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, empty} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL reset_flags: busy/done/empty got %b expected 001", {busy, done, empty});
    end
    checks++;
    if (count !== '0 || read_index !== '0) begin
      errors++;
      $display("[TB] FAIL reset_count: count=%0d read_index=%0d expected 0 and 0", count, read_index);
    end
    checks++;
    if (pack_got() !== 18'h20000) begin
      errors++;
      $display("[TB] FAIL reset_results: got %h expected %h", pack_got(), 18'h20000);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_zero();
    int done_at, busy_bad;
    load_mask(16'h0000);
    run_scan(-1, -1, done_at, busy_bad);
    checks++;
    if (done_at != LAT) begin
      errors++;
      $display("[TB] FAIL zero_latency: done at E0+%0d expected E0+%0d", done_at, LAT);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("[TB] FAIL zero_busy: %0d cycles with wrong busy, expected 0", busy_bad);
    end
    checks++;
    if (pack_got() !== 18'h20000) begin
      errors++;
      $display("[TB] FAIL zero_results: got %h expected %h", pack_got(), 18'h20000);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done_pulse: done got %b expected 0", done);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] dir_masks [3];
    logic [15:0] mask;
    exp_t e;
    int done_at, busy_bad;
    dir_masks[0] = 16'h0020;
    dir_masks[1] = 16'h030F;
    dir_masks[2] = 16'hFFFF;
    for (int i = 0; i < 23; i++) begin
      if (i < 3) mask = dir_masks[i];
      else begin
        case (i % 4)
          0:       mask = 16'($urandom);
          1:       mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2:       mask = 16'($urandom) | 16'($urandom);
          default: mask = 16'h0001 << $urandom_range(0, 15);
        endcase
      end
      load_mask(mask);
      e = ref_model();
      run_scan(-1, -1, done_at, busy_bad);
      checks++;
      if (done_at != LAT || busy_bad != 0) begin
        errors++;
        $display("[TB] FAIL pattern_timing mask=%h: done at %0d busy errors %0d, expected %0d and 0",
                 mask, done_at, busy_bad, LAT);
      end
      checks++;
      if (pack_got() !== pack_exp(e)) begin
        errors++;
        $display("[TB] FAIL pattern_results mask=%h: got emp=%0d cnt=%0d x=%0d..%0d y=%0d..%0d c=(%0d,%0d) expected emp=%0d cnt=%0d x=%0d..%0d y=%0d..%0d c=(%0d,%0d)",
                 mask, empty, count, min_x, max_x, min_y, max_y, cent_x, cent_y,
                 e.emp, e.cnt, e.mnx, e.mxx, e.mny, e.mxy, e.cx, e.cy);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b0 || pack_got() !== pack_exp(e)) begin
        errors++;
        $display("[TB] FAIL pattern_hold mask=%h: done=%b results %h expected 0 and %h",
                 mask, done, pack_got(), pack_exp(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int done_at, busy_bad, extra;
    load_mask(16'h1248);
    e = ref_model();
    run_scan(5, -1, done_at, busy_bad);
    checks++;
    if (done_at != LAT || busy_bad != 0 || pack_got() !== pack_exp(e)) begin
      errors++;
      $display("[TB] FAIL b2b_midscan_pulse: done at %0d busy errors %0d results %h expected %0d 0 %h",
               done_at, busy_bad, pack_got(), LAT, pack_exp(e));
    end
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL b2b_single_done: %0d busy/done cycles after scan, expected 0", extra);
    end

    run_scan(19, -1, done_at, busy_bad);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    checks++;
    if (done_at != LAT || extra != 0) begin
      errors++;
      $display("[TB] FAIL b2b_edge_at_done: done at %0d extra cycles %0d expected %0d and 0",
               done_at, extra, LAT);
    end

    load_mask(16'h8000);
    e = ref_model();
    run_scan(-1, -1, done_at, busy_bad);
    checks++;
    if (done_at != LAT || pack_got() !== pack_exp(e)) begin
      errors++;
      $display("[TB] FAIL b2b_new_frame: done at %0d results %h expected %0d and %h",
               done_at, pack_got(), LAT, pack_exp(e));
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    int done_at, busy_bad, seen;
    load_mask(16'h0F60);
    run_scan(-1, 8, done_at, busy_bad);
    checks++;
    if ({busy, done, empty} !== 3'b001 || read_index !== '0 || pack_got() !== 18'h20000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy/done/empty=%b idx=%0d results %h expected 001 0 %h",
               {busy, done, empty}, read_index, pack_got(), 18'h20000);
    end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done: %0d busy/done cycles after abort, expected 0", seen);
    end
    load_mask(16'($urandom) | 16'h0001);
    e = ref_model();
    run_scan(-1, -1, done_at, busy_bad);
    checks++;
    if (done_at != LAT || busy_bad != 0 || pack_got() !== pack_exp(e)) begin
      errors++;
      $display("[TB] FAIL midreset_rescan: done at %0d busy errors %0d results %h expected %0d 0 %h",
               done_at, busy_bad, pack_got(), LAT, pack_exp(e));
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_patterns();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
